// File: rtl/frame_collect.sv
// Ping-pong frame collector: gathers N streaming complex samples per bank and
// presents a completed frame in natural order to the bit-reverse reorder stage.
package frame_collect_pkg;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } complex_product_t;
endpackage

module frame_collect
  import frame_collect_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  complex_product_t         in_sample,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output complex_product_t [N-1:0] frame_out,
  output logic                     frame_valid,
  input  logic                     frame_ack,
  output logic [$clog2(N):0]       sample_cnt
);

  localparam int AW = $clog2(N);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(N-1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  complex_product_t [N-1:0] bank [2];
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_bank;
  logic       rd_bank;
  logic       accept;
  logic       last;
  logic       consume;

  // in_ready never looks at in_valid, so upstream may gate in_valid on it freely.
  assign in_ready    = !full[wr_bank] && !flush && !reset;
  assign accept      = in_valid && in_ready;
  assign last        = accept && (sample_cnt == CNT_LAST);
  assign consume     = frame_ack && full[rd_bank];
  assign frame_valid = full[rd_bank];
  assign frame_out   = bank[rd_bank];

  // A bank cannot be filled and consumed at the same edge: fill needs it EMPTY, consume needs it FULL.
  always_comb begin
    full_nxt = full;
    if (last)    full_nxt[wr_bank] = 1'b1;
    if (consume) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full       <= 2'b00;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      full <= full_nxt;
      if (last)    wr_bank <= ~wr_bank;
      if (consume) rd_bank <= ~rd_bank;
      if (flush)
        sample_cnt <= '0;
      else if (last)
        sample_cnt <= '0;
      else if (accept)
        sample_cnt <= sample_cnt + CNT_ONE;
    end
  end

  // Bank storage is cleared only by reset so frame_out reads zero while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        bank[b] <= '0;
    end else if (accept) begin
      bank[wr_bank][sample_cnt[AW-1:0]] <= in_sample;
    end
  end

endmodule

// File: tb/tb_frame_collect.sv
// Bench for frame_collect: directed scenarios plus random traffic checked
// against a queue-based model of completed and partial frames.
module tb_frame_collect;
  import frame_collect_pkg::*;

  localparam int N  = 8;
  localparam int CW = $clog2(N) + 1;

  typedef complex_product_t [N-1:0] frame_t;

  logic             clk = 1'b0;
  logic             reset;
  complex_product_t in_sample;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  frame_t           frame_out;
  logic             frame_valid;
  logic             frame_ack;
  logic [CW-1:0]    sample_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  frame_t           fq[$];
  complex_product_t part[$];

  always #5 clk = ~clk;

  frame_collect #(.N(N)) dut (
    .clk(clk),
    .reset(reset),
    .in_sample(in_sample),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush(flush),
    .frame_out(frame_out),
    .frame_valid(frame_valid),
    .frame_ack(frame_ack),
    .sample_cnt(sample_cnt)
  );

  function automatic complex_product_t mk(int v);
    complex_product_t c;
    c.re = DATA_W'(v);
    c.im = DATA_W'(-v);
    return c;
  endfunction

  function automatic frame_t seq(int base);
    frame_t f;
    for (int k = 0; k < N; k++) f[k] = mk(base + k);
    return f;
  endfunction

  function automatic logic m_ready();
    return (fq.size() < 2) && !flush && !reset;
  endfunction

  task automatic model_reset();
    fq.delete();
    part.delete();
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    frame_ack = 1'b0;
  endtask

  // One clock of the reference model, evaluated with the inputs present before the edge.
  task automatic tick();
    bit acc;
    bit cons;
    frame_t f;
    acc  = in_valid && !flush && !reset && (fq.size() < 2);
    cons = frame_ack && !reset && (fq.size() > 0);
    @(posedge clk);
    if (flush) part.delete();
    if (acc) part.push_back(in_sample);
    if (cons) void'(fq.pop_front());
    if (part.size() == N) begin
      for (int k = 0; k < N; k++) f[k] = part[k];
      fq.push_back(f);
      part.delete();
    end
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 2; i++) begin
      frame_ack = 1'b1;
      tick();
    end
    frame_ack = 1'b0;
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid: got %b want 0", frame_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    in_valid  = 1'b1;
    in_sample = mk(7);
    #2;
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    n_cmp++; if (sample_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", sample_cnt); end
    n_cmp++; if (frame_out !== '0) begin n_bad++; $display("FAIL reset_out: got %h want 0", frame_out); end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_basic();
    in_valid = 1'b1;
    for (int k = 1; k <= N; k++) begin
      in_sample = mk(k);
      #1;
      n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid k=%0d: got %b want 0", k, frame_valid); end
      tick();
      if (k < N) begin
        n_cmp++; if (sample_cnt !== CW'(k)) begin n_bad++; $display("FAIL basic_cnt k=%0d: got %0d want %0d", k, sample_cnt, k); end
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", frame_valid); end
    n_cmp++; if (frame_out !== seq(1)) begin n_bad++; $display("FAIL basic_out: got %h want %h", frame_out, seq(1)); end
    n_cmp++; if (sample_cnt !== '0) begin n_bad++; $display("FAIL basic_cnt_wrap: got %0d want 0", sample_cnt); end
  endtask

  task automatic test_fill();
    int idx;
    logic rdy;
    idx = 9;
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_sample = mk(idx);
      #1;
      rdy = in_ready;
      n_cmp++; if (rdy !== m_ready()) begin n_bad++; $display("FAIL fill_ready c=%0d: got %b want %b", c, rdy, m_ready()); end
      tick();
      if (rdy) idx++;
    end
    n_cmp++; if (idx !== 17) begin n_bad++; $display("FAIL fill_accepted: got next=%0d want 17", idx); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_stall_ready: got %b want 0", in_ready); end
    n_cmp++; if (frame_out !== seq(1)) begin n_bad++; $display("FAIL fill_hold_out: got %h want %h", frame_out, seq(1)); end
    frame_ack = 1'b1;
    in_sample = mk(17);
    tick();
    frame_ack = 1'b0;
    in_valid  = 1'b0;
    #1;
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL fill_next_valid: got %b want 1", frame_valid); end
    n_cmp++; if (frame_out !== seq(9)) begin n_bad++; $display("FAIL fill_next_out: got %h want %h", frame_out, seq(9)); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_next_ready: got %b want 1", in_ready); end
    drain();
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_sample = mk(50 + k);
      tick();
    end
    n_cmp++; if (sample_cnt !== CW'(3)) begin n_bad++; $display("FAIL flush_pre_cnt: got %0d want 3", sample_cnt); end
    flush     = 1'b1;
    in_sample = mk(53);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    n_cmp++; if (sample_cnt !== '0) begin n_bad++; $display("FAIL flush_cnt: got %0d want 0", sample_cnt); end
    for (int k = 0; k < N; k++) begin
      in_sample = mk(100 + k);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (frame_out !== seq(100)) begin n_bad++; $display("FAIL flush_out: got %h want %h", frame_out, seq(100)); end
    n_cmp++; if (sample_cnt !== '0) begin n_bad++; $display("FAIL flush_end_cnt: got %0d want 0", sample_cnt); end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL flush_valid: got %b want 1", frame_valid); end
    drain();
  endtask

  task automatic test_same_cycle();
    in_valid = 1'b1;
    for (int k = 0; k < 2 * N; k++) begin
      in_sample = mk(200 + k);
      frame_ack = (k == 2 * N - 1);
      tick();
    end
    idle();
    #1;
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL same_valid: got %b want 1", frame_valid); end
    n_cmp++; if (frame_out !== seq(200 + N)) begin n_bad++; $display("FAIL same_out: got %h want %h", frame_out, seq(200 + N)); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL same_ready: got %b want 1", in_ready); end
    n_cmp++; if (sample_cnt !== '0) begin n_bad++; $display("FAIL same_cnt: got %0d want 0", sample_cnt); end
    drain();
  endtask

  task automatic test_ack_idle();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_sample = mk(300 + k);
      tick();
    end
    in_valid  = 1'b0;
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    n_cmp++; if (sample_cnt !== CW'(3)) begin n_bad++; $display("FAIL ackidle_cnt: got %0d want 3", sample_cnt); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL ackidle_valid: got %b want 0", frame_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ackidle_ready: got %b want 1", in_ready); end
    in_valid = 1'b1;
    for (int k = 3; k < N; k++) begin
      in_sample = mk(300 + k);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (frame_out !== seq(300)) begin n_bad++; $display("FAIL ackidle_out: got %h want %h", frame_out, seq(300)); end
    drain();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    for (int k = 0; k < N + 5; k++) begin
      in_sample = (k < N) ? mk(400 + k) : mk(410 + k);
      tick();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", frame_valid); end
    n_cmp++; if (sample_cnt !== '0) begin n_bad++; $display("FAIL rstmid_cnt: got %0d want 0", sample_cnt); end
    n_cmp++; if (frame_out !== '0) begin n_bad++; $display("FAIL rstmid_out: got %h want 0", frame_out); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      in_sample = mk(500 + k);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_new_valid: got %b want 1", frame_valid); end
    n_cmp++; if (frame_out !== seq(500)) begin n_bad++; $display("FAIL rstmid_new_out: got %h want %h", frame_out, seq(500)); end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      frame_ack = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_sample = complex_product_t'($urandom);
      #1;
      n_cmp++; if (in_ready !== m_ready()) begin n_bad++; $display("FAIL rand_ready c=%0d: got %b want %b", c, in_ready, m_ready()); end
      tick();
      n_cmp++; if (frame_valid !== (fq.size() > 0)) begin n_bad++; $display("FAIL rand_valid c=%0d: got %b want %b", c, frame_valid, fq.size() > 0); end
      n_cmp++; if (sample_cnt !== CW'(part.size())) begin n_bad++; $display("FAIL rand_cnt c=%0d: got %0d want %0d", c, sample_cnt, part.size()); end
      if (fq.size() > 0) begin
        n_cmp++; if (frame_out !== fq[0]) begin n_bad++; $display("FAIL rand_out c=%0d: got %h want %h", c, frame_out, fq[0]); end
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_flush();
    test_same_cycle();
    test_ack_idle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_collect.md
FRAME_COLLECT -- requirements
Module: frame_collect

Interface
REQ-001 Parameter: N, default 8, number of complex samples per frame; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_sample  input  complex_product_t  streaming sample, one per accepted transfer.
REQ-005 in_valid  input  1  in_sample is valid this cycle.
REQ-006 in_ready  output  1  block can accept in_sample this cycle.
REQ-007 flush  input  1  synchronous, discards the partially filled frame.
REQ-008 frame_out  output  complex_product_t [N-1:0]  completed frame, natural order; drives the bit-reverse reorder stage.
REQ-009 frame_valid  output  1  frame_out holds a complete frame; used as enable for the downstream stage.
REQ-010 frame_ack  input  1  downstream has consumed frame_out this cycle.
REQ-011 sample_cnt  output  $clog2(N)+1  samples written into the current write bank, 0..N-1.

Function
REQ-012 Storage SHALL be two banks of N samples (ping-pong), each with a FULL/EMPTY flag, plus a write-bank pointer wr_bank, a read-bank pointer rd_bank, and a sample counter.
REQ-013 A transfer SHALL occur only in a cycle with in_valid=1 and in_ready=1; in_sample SHALL then be written to bank[wr_bank][sample_cnt] and sample_cnt SHALL increment.
REQ-014 in_ready SHALL equal NOT FULL(bank[wr_bank]) AND NOT flush AND NOT reset; it is combinational from registers and flush only, with no path from in_valid.
REQ-015 On the Nth transfer of a frame: bank[wr_bank] SHALL be marked FULL, sample_cnt SHALL wrap to 0, and wr_bank SHALL toggle, all at the same edge.
REQ-016 frame_valid SHALL equal FULL(bank[rd_bank]); frame_out SHALL equal bank[rd_bank] contents.
REQ-017 frame_valid SHALL rise in the cycle after the Nth transfer, so latency from the last sample to frame_valid is 1 cycle.
REQ-018 Sample k of a frame (k counted from 0) SHALL appear on frame_out[k].
REQ-019 frame_ack=1 with frame_valid=1 SHALL mark bank[rd_bank] EMPTY and toggle rd_bank at the next edge.
REQ-020 If the other bank is already FULL when frame_ack clears the current bank, frame_valid SHALL remain 1 and frame_out SHALL show the other bank's frame the next cycle.
REQ-021 frame_ack=1 with frame_valid=0 SHALL be ignored, with no state change.
REQ-022 frame_out and frame_valid SHALL stay stable while frame_valid=1 and frame_ack=0.
REQ-023 Both banks FULL: in_ready=0; in_valid is held off, and no sample is lost or overwritten.
REQ-024 Simultaneous Nth transfer into one bank and frame_ack of the other bank in the same cycle: both actions SHALL take effect at the same edge.
REQ-025 flush=1: sample_cnt SHALL clear to 0 and the partial frame SHALL be discarded; no transfer occurs that cycle; FULL banks, rd_bank and wr_bank SHALL be unaffected; frame_ack SHALL still be honoured.
REQ-026 Bank data registers need not be cleared on consume; only the flags govern validity.

Reset
REQ-027 While reset=1: both banks EMPTY, all bank data 0, wr_bank=0, rd_bank=0, sample_cnt=0.
REQ-028 While reset=1: outputs frame_valid=0, in_ready=0, and frame_out all-zero.
REQ-029 Reset asserted mid-frame or with frames pending SHALL discard everything immediately and asynchronously.
REQ-030 After reset deasserts, in_ready=1 in the first cycle.

Verification
REQ-031 N=8, in_valid held high, samples 1..8, frame_ack=0: frame_valid rises 1 cycle after sample 8; frame_out[0..7]=1..8.
REQ-032 Continue samples 9..24 with frame_ack=0: samples 9..16 are accepted and in_ready drops after sample 16; frame_out still shows 1..8. Pulse frame_ack: next cycle frame_out=9..16 and frame_valid stays 1, and in_ready=1.
REQ-033 Send 3 samples, assert flush for 1 cycle together with in_valid, then send 8 samples 100..107: frame_out=100..107 and sample_cnt=0 after the last sample.
REQ-034 Same-cycle case: bank A FULL, 8th sample into bank B in the same cycle as frame_ack: next cycle frame_valid=1, frame_out shows bank B data, and in_ready=1.
REQ-035 Assert reset after 5 samples with one frame pending: frame_valid=0, sample_cnt=0 and frame_out=0 immediately, without waiting for a clock edge; a new 8-sample frame then completes normally.
REQ-036 frame_ack pulsed while frame_valid=0: no change to sample_cnt, frame_valid, in_ready or the bank pointers.
